// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: register file geometry and
// the producer latency codes used by DECODE.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
  localparam int LAT_WIDTH      = 2;
  localparam int STAT_WIDTH     = 32;

  // Cycles a back-to-back consumer must wait behind a producer of each class.
  typedef enum logic [LAT_WIDTH-1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_DIV  = 2'd3
  } lat_code_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// DECODE <-> scoreboard signal bundle. The master side is the pipeline
// (DECODE plus the global stall/flush sources); the slave is the scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = hazard_scoreboard_pkg::REG_ADDR_WIDTH,
  parameter int NUM_REGS       = hazard_scoreboard_pkg::NUM_REGS,
  parameter int LAT_WIDTH      = hazard_scoreboard_pkg::LAT_WIDTH,
  parameter int STAT_WIDTH     = hazard_scoreboard_pkg::STAT_WIDTH
) ();

  logic                      i_DEC_Valid;
  logic                      i_DEC_Uses_RS;
  logic [REG_ADDR_WIDTH-1:0] i_DEC_RS_Addr;
  logic                      i_DEC_Uses_RT;
  logic [REG_ADDR_WIDTH-1:0] i_DEC_RT_Addr;
  logic                      i_DEC_Writes_Back;
  logic [REG_ADDR_WIDTH-1:0] i_DEC_Write_Addr;
  logic [LAT_WIDTH-1:0]      i_DEC_Latency;
  logic                      i_Pipe_Stall;
  logic                      i_Flush;
  logic                      o_DEC_Stall;
  logic [NUM_REGS-1:0]       o_Pending_Mask;
  logic [STAT_WIDTH-1:0]     o_Stall_Cycles;

  modport master (
    output i_DEC_Valid, i_DEC_Uses_RS, i_DEC_RS_Addr, i_DEC_Uses_RT,
           i_DEC_RT_Addr, i_DEC_Writes_Back, i_DEC_Write_Addr,
           i_DEC_Latency, i_Pipe_Stall, i_Flush,
    input  o_DEC_Stall, o_Pending_Mask, o_Stall_Cycles
  );

  modport slave (
    input  i_DEC_Valid, i_DEC_Uses_RS, i_DEC_RS_Addr, i_DEC_Uses_RT,
           i_DEC_RT_Addr, i_DEC_Writes_Back, i_DEC_Write_Addr,
           i_DEC_Latency, i_Pipe_Stall, i_Flush,
    output o_DEC_Stall, o_Pending_Mask, o_Stall_Cycles
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: a down-counter holding the number of cycles until
// the youngest in-flight producer of this register reaches a bypass source.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_WIDTH = hazard_scoreboard_pkg::LAT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [LAT_WIDTH-1:0] lat_i,
  input  logic                 freeze_i,
  output logic                 pending_o
);

  logic [LAT_WIDTH-1:0] cnt_q;
  logic [LAT_WIDTH-1:0] cnt_d;

  // Next count: freeze holds, a new producer overrides the old count
  // (youngest writer wins), otherwise count down towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      if (load_i) begin
        cnt_d = lat_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter register; reset discards any in-flight producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / multi-cycle interlock. Tracks registers whose producer cannot
// yet be forwarded and stalls DECODE while a source operand hits one.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = hazard_scoreboard_pkg::REG_ADDR_WIDTH,
  parameter int NUM_REGS       = hazard_scoreboard_pkg::NUM_REGS,
  parameter int LAT_WIDTH      = hazard_scoreboard_pkg::LAT_WIDTH,
  parameter int STAT_WIDTH     = hazard_scoreboard_pkg::STAT_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  hazard_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   load_vec;
  logic                  rs_hit;
  logic                  rt_hit;
  logic                  stall;
  logic                  issue;
  logic                  wr_en;
  logic [STAT_WIDTH-1:0] stat_q;
  logic [STAT_WIDTH-1:0] stat_d;

  // Read-side lookups. r0 is hard-wired so its pending bit is always 0,
  // but the explicit address check keeps the intent obvious.
  assign rs_hit = sb.i_DEC_Uses_RS && (sb.i_DEC_RS_Addr != '0) && pending[sb.i_DEC_RS_Addr];
  assign rt_hit = sb.i_DEC_Uses_RT && (sb.i_DEC_RT_Addr != '0) && pending[sb.i_DEC_RT_Addr];

  // The stall depends only on decode inputs and registered counters; the
  // global freeze deliberately has no path into it.
  assign stall = sb.i_DEC_Valid && (rs_hit || rt_hit);

  assign issue = sb.i_DEC_Valid && !stall && !sb.i_Pipe_Stall && !sb.i_Flush;
  assign wr_en = issue && sb.i_DEC_Writes_Back;

  // Entry 0 never holds a producer.
  assign load_vec[0] = 1'b0;
  assign pending[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    assign load_vec[r] = wr_en && (sb.i_DEC_Write_Addr == REG_ADDR_WIDTH'(r));

    scoreboard_entry #(
      .LAT_WIDTH (LAT_WIDTH)
    ) u_entry (
      .clk       (clock),
      .rst       (reset),
      .load_i    (load_vec[r]),
      .lat_i     (sb.i_DEC_Latency),
      .freeze_i  (sb.i_Pipe_Stall),
      .pending_o (pending[r])
    );
  end

  // Stall statistics: count unfrozen stall cycles, sticking at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (stall && !sb.i_Pipe_Stall && (stat_q != '1)) begin
      stat_d = stat_q + 1'b1;
    end
  end

  // Statistics register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign sb.o_DEC_Stall    = stall;
  assign sb.o_Pending_Mask = pending;
  assign sb.o_Stall_Cycles = stat_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clock;
  logic reset;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard u_dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic        urs;
    logic [4:0]  rs;
    logic        urt;
    logic [4:0]  rt;
    logic        wb;
    logic [4:0]  wa;
    logic [1:0]  lat;
    logic        ps;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_mask;
    int          e_stat;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic valid, input logic urs, input int rs,
                     input logic urt, input int rt, input logic wb,
                     input int wa, input int lat, input logic ps,
                     input logic fl, input logic e_stall,
                     input logic [31:0] e_mask, input int e_stat);
    vec_t v;
    v.valid = valid; v.urs = urs; v.rs = 5'(rs); v.urt = urt; v.rt = 5'(rt);
    v.wb = wb; v.wa = 5'(wa); v.lat = 2'(lat); v.ps = ps; v.fl = fl;
    v.e_stall = e_stall; v.e_mask = e_mask; v.e_stat = e_stat;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.i_DEC_Valid       = v.valid;
    sb_if.i_DEC_Uses_RS     = v.urs;
    sb_if.i_DEC_RS_Addr     = v.rs;
    sb_if.i_DEC_Uses_RT     = v.urt;
    sb_if.i_DEC_RT_Addr     = v.rt;
    sb_if.i_DEC_Writes_Back = v.wb;
    sb_if.i_DEC_Write_Addr  = v.wa;
    sb_if.i_DEC_Latency     = v.lat;
    sb_if.i_Pipe_Stall      = v.ps;
    sb_if.i_Flush           = v.fl;
  endtask

  task automatic check_outputs(input string tag, input logic e_stall,
                               input logic [31:0] e_mask, input int e_stat);
    chk({tag, ".stall"}, 64'(sb_if.o_DEC_Stall), 64'(e_stall));
    chk({tag, ".mask"},  64'(sb_if.o_Pending_Mask), 64'(e_mask));
    chk({tag, ".stat"},  64'(sb_if.o_Stall_Cycles), 64'(e_stat));
  endtask

  vec_t idle_v;
  vec_t v;

  initial begin
    // valid urs rs urt rt wb wa lat ps fl | stall mask stat
    // load-use: load r5, then add r6,r5,r1
    add(1, 0, 0, 0, 0, 1, 5,  LAT_LOAD, 0, 0, 0, 32'h0,   0);
    add(1, 1, 5, 1, 1, 1, 6,  LAT_ALU,  0, 0, 1, 32'h20,  0);
    add(1, 1, 5, 1, 1, 1, 6,  LAT_ALU,  0, 0, 0, 32'h0,   1);
    // ALU chain on r3
    add(1, 0, 0, 0, 0, 1, 3,  LAT_ALU,  0, 0, 0, 32'h0,   1);
    add(1, 1, 3, 0, 0, 1, 8,  LAT_ALU,  0, 0, 0, 32'h0,   1);
    // load to r0, then reader of r0
    add(1, 0, 0, 0, 0, 1, 0,  LAT_LOAD, 0, 0, 0, 32'h0,   1);
    add(1, 1, 0, 1, 0, 1, 11, LAT_ALU,  0, 0, 0, 32'h0,   1);
    // latency-2 write to r7, three frozen cycles, then two real stalls
    add(1, 0, 0, 0, 0, 1, 7,  LAT_MUL,  0, 0, 0, 32'h0,   1);
    add(1, 1, 7, 0, 0, 0, 0,  0,        1, 0, 1, 32'h80,  1);
    add(1, 1, 7, 0, 0, 0, 0,  0,        1, 0, 1, 32'h80,  1);
    add(1, 1, 7, 0, 0, 0, 0,  0,        1, 0, 1, 32'h80,  1);
    add(1, 1, 7, 0, 0, 0, 0,  0,        0, 0, 1, 32'h80,  1);
    add(1, 1, 7, 0, 0, 0, 0,  0,        0, 0, 1, 32'h80,  2);
    add(1, 1, 7, 0, 0, 0, 0,  0,        0, 0, 0, 32'h0,   3);
    // WAW: latency-3 then latency-0 write to r9
    add(1, 0, 0, 0, 0, 1, 9,  LAT_DIV,  0, 0, 0, 32'h0,   3);
    add(1, 0, 0, 0, 0, 1, 9,  LAT_ALU,  0, 0, 0, 32'h200, 3);
    add(0, 0, 0, 0, 0, 0, 0,  0,        0, 0, 0, 32'h0,   3);
    // collision: load lat 1 to r9 while counter[9] decrements from 3
    add(1, 0, 0, 0, 0, 1, 9,  LAT_DIV,  0, 0, 0, 32'h0,   3);
    add(1, 0, 0, 0, 0, 1, 9,  LAT_LOAD, 0, 0, 0, 32'h200, 3);
    add(1, 0, 0, 1, 9, 0, 0,  0,        0, 0, 1, 32'h200, 3);
    add(1, 0, 0, 1, 9, 0, 0,  0,        0, 0, 0, 32'h0,   4);
    // flushed latency-3 write to r4, then a reader of r4
    add(1, 0, 0, 0, 0, 1, 4,  LAT_DIV,  0, 1, 0, 32'h0,   4);
    add(1, 1, 4, 0, 0, 0, 0,  0,        0, 0, 0, 32'h0,   4);
    // latency-3 producer: dependent stalls exactly three cycles
    add(1, 0, 0, 0, 0, 1, 10, LAT_DIV,  0, 0, 0, 32'h0,   4);
    add(1, 1, 10, 0, 0, 1, 12, LAT_ALU, 0, 0, 1, 32'h400, 4);
    add(1, 1, 10, 0, 0, 1, 12, LAT_ALU, 0, 0, 1, 32'h400, 5);
    add(1, 1, 10, 0, 0, 1, 12, LAT_ALU, 0, 0, 1, 32'h400, 6);
    add(1, 1, 10, 0, 0, 1, 12, LAT_ALU, 0, 0, 0, 32'h0,   7);

    idle_v = '{default: '0};
    reset = 1'b1;
    drive(idle_v);
    #3;
    check_outputs("reset", 1'b0, 32'h0, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clock);
      check_outputs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_mask, tbl[i].e_stat);
      @(posedge clock);
      #1;
    end

    // Asynchronous reset while counter[2] = 2, with a reader of r2 in DECODE.
    v = idle_v;
    v.valid = 1'b1; v.wb = 1'b1; v.wa = 5'd2; v.lat = LAT_DIV;
    drive(v);
    @(posedge clock);
    #1 drive(idle_v);
    @(posedge clock);
    #1;
    v = idle_v;
    v.valid = 1'b1; v.urs = 1'b1; v.rs = 5'd2;
    drive(v);
    @(negedge clock);
    check_outputs("prerst", 1'b1, 32'h4, 7);
    #1 reset = 1'b1;
    #1;
    check_outputs("asyncrst", 1'b0, 32'h0, 0);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check_outputs("postrst0", 1'b0, 32'h0, 0);
    @(posedge clock);
    #1;
    check_outputs("postrst1", 1'b0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
